// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared types and helpers for the serial adder/subtractor.
//   state_e      : control FSM states (IDLE, RUN, DONE)
//   OP_ADD/OP_SUB: encoding of the 'sub' operand-select input
//   chunk_count  : number of RUN cycles per operation (WIDTH/STEP)
//   cnt_width    : width of the chunk counter ($clog2 of chunk count, min 1)
// ---------------------------------------------------------------------------
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int chunk_count(input int width, input int step);
    return width / step;
  endfunction

  function automatic int cnt_width(input int width, input int step);
    int n;
    n = width / step;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// ---------------------------------------------------------------------------
// addsub_chunk
// Combinational STEP-bit ripple-carry adder slice.
// Ports:
//   a_i, b_i  : STEP-bit addends
//   cin_i     : carry in
//   sum_o     : STEP-bit sum
//   cout_o    : carry out of the slice MSB
// ---------------------------------------------------------------------------
module addsub_chunk #(
  parameter int STEP = 1
) (
  input  logic [STEP-1:0] a_i,
  input  logic [STEP-1:0] b_i,
  input  logic            cin_i,
  output logic [STEP-1:0] sum_o,
  output logic            cout_o
);

  logic [STEP:0] c;

  always_comb begin
    // NOTE: every variable driven here gets a default first so no path can infer a latch.
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < STEP; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = c[STEP];

endmodule

// File: rtl/serial_add_sub.sv
// ---------------------------------------------------------------------------
// serial_add_sub
// Multi-cycle adder/subtractor: processes STEP bits per clock, LSB first,
// through a single shared addsub_chunk slice. valid/ready on both sides.
// Optional build macro: ADDSUB_SAT_EN -- clamp result to signed max/min on
// overflow (carry/overflow flags still report the unsaturated condition).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (accepted only in IDLE)
//   a, b, sub           : operands, 0 = A+B, 1 = A-B
//   out_valid/out_ready : result handshake (held in DONE until taken)
//   result, carry       : sum/difference, carry out (sub: 1 = no borrow)
//   overflow            : two's-complement overflow
//   busy                : high while in RUN or DONE
// ---------------------------------------------------------------------------
module serial_add_sub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int             CHUNKS = chunk_count(WIDTH, STEP);
  localparam int             CW     = cnt_width(WIDTH, STEP);
  localparam logic [CW-1:0]  LAST   = CW'(CHUNKS - 1);

  if ((WIDTH < 2) || (WIDTH % STEP != 0)) begin : g_bad_params
    $error("serial_add_sub: WIDTH must be >= 2 and a multiple of STEP");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;      // latched A, shifted right each RUN cycle
  logic [WIDTH-1:0]  b_q, b_d;      // latched B' = B ^ {sub}, shifted likewise
  logic              c_q, c_d;      // running carry between chunks
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;  // partial sum, filled from the MSB end
  logic [WIDTH-1:0]  res_q, res_d;  // visible result, updated only on completion
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;

  logic [STEP-1:0]       slice_sum;
  logic                  slice_cout;
  logic [WIDTH+STEP-1:0] acc_cat;
  logic [WIDTH-1:0]      acc_shift;
  logic                  a_msb, b_msb, ovf_now;
  logic [WIDTH-1:0]      res_final;

  addsub_chunk #(.STEP(STEP)) u_chunk (
    .a_i    (a_q[STEP-1:0]),
    .b_i    (b_q[STEP-1:0]),
    .cin_i  (c_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // New chunk enters at the top; everything below moves down by STEP.
  assign acc_cat   = {slice_sum, acc_q};
  assign acc_shift = acc_cat[WIDTH+STEP-1:STEP];

  // On the last chunk the low STEP bits of a_q/b_q hold the original top
  // chunk, so bit STEP-1 is the operand MSB.
  assign a_msb   = a_q[STEP-1];
  assign b_msb   = b_q[STEP-1];
  assign ovf_now = (a_msb == b_msb) && (acc_shift[WIDTH-1] != a_msb);

`ifdef ADDSUB_SAT_EN
  assign res_final = !ovf_now ? acc_shift
                   : a_msb    ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign res_final = acc_shift;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub == OP_SUB}};
          c_d     = (sub == OP_ADD) ? 1'b0 : 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> STEP;
        b_d   = b_q >> STEP;
        c_d   = slice_cout;
        acc_d = acc_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          res_d   = res_final;
          carry_d = slice_cout;
          ovf_d   = ovf_now;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = res_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_add_sub
// Two instances: WIDTH=4/STEP=1 driven from a vector table, and
// WIDTH=8/STEP=4 driven by hand-written sequences (hold, back-to-back,
// asynchronous reset mid-operation). Honours ADDSUB_SAT_EN for expectations.
// ---------------------------------------------------------------------------
module tb_serial_add_sub;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4, STEP=1 instance
  logic       iv4, ir4, sub4, ov4, or4, c4, v4, busy4;
  logic [3:0] a4, b4, r4;
  // WIDTH=8, STEP=4 instance
  logic       iv8, ir8, sub8, ov8, or8, c8, v8, busy8;
  logic [7:0] a8, b8, r8;

  serial_add_sub #(.WIDTH(4), .STEP(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .sub(sub4), .out_valid(ov4), .out_ready(or4), .result(r4), .carry(c4),
    .overflow(v4), .busy(busy4));

  serial_add_sub #(.WIDTH(8), .STEP(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .sub(sub8), .out_valid(ov8), .out_ready(or8), .result(r8), .carry(c8),
    .overflow(v8), .busy(busy8));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic [3:0] res;   // wrapped result
    logic [3:0] rsat;  // result when saturation is built in
    logic       c;
    logic       v;
  } vec_t;

  vec_t tbl[10];

  task automatic op4(input vec_t v, input int idx);
    int         n;
    logic [3:0] prev;
    @(negedge clk);
    check($sformatf("w4[%0d] in_ready idle", idx), 32'(ir4), 32'd1);
    prev = r4;
    iv4  = 1'b1; a4 = v.a; b4 = v.b; sub4 = v.sub;
    @(posedge clk); #1;
    // Scramble inputs: nothing outside IDLE may sample them.
    iv4 = 1'b0; a4 = ~v.a; b4 = ~v.b; sub4 = ~v.sub;
    check($sformatf("w4[%0d] busy in run", idx), 32'(busy4), 32'd1);
    check($sformatf("w4[%0d] result held in run", idx), 32'(r4), 32'(prev));
    n = 0;
    while (ov4 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("w4[%0d] latency", idx), 32'(n), 32'd4);
    check($sformatf("w4[%0d] result", idx), 32'(r4), 32'(SAT ? v.rsat : v.res));
    check($sformatf("w4[%0d] carry", idx), 32'(c4), 32'(v.c));
    check($sformatf("w4[%0d] overflow", idx), 32'(v4), 32'(v.v));
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    check($sformatf("w4[%0d] out_valid drop", idx), 32'(ov4), 32'd0);
  endtask

  initial begin
    int n;
    int m;
    iv4 = 0; or4 = 0; a4 = '0; b4 = '0; sub4 = 0;
    iv8 = 0; or8 = 0; a8 = '0; b8 = '0; sub8 = 0;

    // Reset state (sampled while reset is held)
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 32'(ir4), 32'd1);
    check("rst out_valid", 32'(ov4), 32'd0);
    check("rst busy", 32'(busy4), 32'd0);
    check("rst result", 32'(r4), 32'd0);
    check("rst carry", 32'(c4), 32'd0);
    check("rst overflow", 32'(v4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //          a        b        sub   res      rsat     c     v
    tbl[0] = '{4'b0001, 4'b0001, 1'b0, 4'b0010, 4'b0010, 1'b0, 1'b0};
    tbl[1] = '{4'b1001, 4'b0011, 1'b0, 4'b1100, 4'b1100, 1'b0, 1'b0};
    tbl[2] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0};
    tbl[3] = '{4'b0001, 4'b1001, 1'b1, 4'b1000, 4'b0111, 1'b0, 1'b1};
    tbl[4] = '{4'b1001, 4'b0011, 1'b1, 4'b0110, 4'b1000, 1'b1, 1'b1};
    tbl[5] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 4'b0111, 1'b0, 1'b1};
    tbl[6] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0};
    tbl[7] = '{4'b1000, 4'b0001, 1'b1, 4'b0111, 4'b1000, 1'b1, 1'b1};
    tbl[8] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0};
    tbl[9] = '{4'b0101, 4'b0111, 1'b1, 4'b1110, 4'b1110, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) op4(tbl[i], i);

    // WIDTH=8 STEP=4: 0x7F + 0x01, latency 2, then hold under backpressure
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    n = 0;
    while (ov8 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8 latency", 32'(n), 32'd2);
    check("w8 result", 32'(r8), SAT ? 32'h7F : 32'h80);
    check("w8 carry", 32'(c8), 32'd0);
    check("w8 overflow", 32'(v8), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("w8 hold%0d", k),
            {20'd0, ov8, ir8, busy8, c8, v8, 1'b0, r8[5:0]} | (32'(r8) << 24),
            {20'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, (SAT ? 6'h3F : 6'h00)}
              | ((SAT ? 32'h7F : 32'h80) << 24));
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    check("w8 released", 32'(ov8), 32'd0);

    // Back-to-back with in_valid and out_ready held high: period WIDTH/STEP+2
    @(negedge clk);
    iv8 = 1'b1; or8 = 1'b1; a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0;
    n = 0;
    while (ov8 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b first result", 32'(r8), 32'h30);
    @(posedge clk); #1;
    m = 0;
    while (ov8 !== 1'b1 && m < 20) begin
      @(posedge clk); #1;
      m++;
    end
    check("b2b period", 32'(m + 1), 32'd4);
    iv8 = 1'b0;
    @(posedge clk); #1;
    or8 = 1'b0;

    // Asynchronous reset in RUN
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'h10; b8 = 8'h01; sub8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    check("pre-abort busy", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(ov8), 32'd0);
    check("abort busy", 32'(busy8), 32'd0);
    check("abort in_ready", 32'(ir8), 32'd1);
    check("abort result", 32'(r8), 32'd0);
    check("abort flags", {30'd0, c8, v8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x10 - 0x01 after reset
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'h10; b8 = 8'h01; sub8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    n = 0;
    while (ov8 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("post-rst latency", 32'(n), 32'd2);
    check("post-rst result", 32'(r8), 32'h0F);
    check("post-rst carry", 32'(c8), 32'd1);
    check("post-rst overflow", 32'(v8), 32'd0);
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
